// File: rtl/amux_bbm_sequencer.sv
// Break-before-make sequencer for the two analog mux buses: serialises connect/disconnect
// requests, enforces dead-time before closure and a settle interval before reporting ready.
module amux_bbm_sequencer #(
   parameter int N_CH          = 8,
   parameter int CH_W          = $clog2(N_CH),
   parameter int BREAK_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_bus,
   input  logic [CH_W-1:0] req_ch,
   input  logic            req_off,
   output logic [N_CH-1:0] amux_a_en,
   output logic [N_CH-1:0] amux_b_en,
   output logic            busy,
   output logic            settled_a,
   output logic            settled_b,
   output logic            err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BREAK,
      S_SETTLE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  timer;
   logic              lat_bus;
   logic              lat_off;
   logic [N_CH-1:0]   lat_sel;

   logic [N_CH-1:0]   req_sel;
   logic [N_CH-1:0]   tgt_en;
   logic [N_CH-1:0]   oth_en;
   logic              ch_ok;
   logic              conflict;
   logic              noop;

   // Out-of-range channels decode to an all-zero select, so they can never alias a valid bit.
   always_comb begin
      req_sel = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (32'(req_ch) == i) req_sel[i] = 1'b1;
      end
      ch_ok    = (32'(req_ch) < 32'(N_CH));
      tgt_en   = req_bus ? amux_b_en : amux_a_en;
      oth_en   = req_bus ? amux_a_en : amux_b_en;
      conflict = |(req_sel & oth_en);
      noop     = req_off ? (tgt_en == '0) : (tgt_en == req_sel);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         timer     <= '0;
         lat_bus   <= 1'b0;
         lat_off   <= 1'b0;
         lat_sel   <= '0;
         amux_a_en <= '0;
         amux_b_en <= '0;
         settled_a <= 1'b0;
         settled_b <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (!req_off && (!ch_ok || conflict)) begin
                     err <= 1'b1;
                  end else if (!noop) begin
                     if (req_bus) begin
                        amux_b_en <= '0;
                        settled_b <= 1'b0;
                     end else begin
                        amux_a_en <= '0;
                        settled_a <= 1'b0;
                     end
                     timer     <= CNT_W'(BREAK_CYCLES - 1);
                     lat_bus   <= req_bus;
                     lat_off   <= req_off;
                     lat_sel   <= req_sel;
                     busy      <= 1'b1;
                     req_ready <= 1'b0;
                     state     <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (timer == '0) begin
                  if (lat_off) begin
                     busy      <= 1'b0;
                     req_ready <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     if (lat_bus) amux_b_en <= lat_sel;
                     else         amux_a_en <= lat_sel;
                     timer <= CNT_W'(SETTLE_CYCLES - 1);
                     state <= S_SETTLE;
                  end
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end
            S_SETTLE: begin
               if (timer == '0) begin
                  if (lat_bus) settled_b <= 1'b1;
                  else         settled_a <= 1'b1;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end
            default: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_amux_bbm_sequencer.sv
// Directed plus randomized bench for amux_bbm_sequencer against an elapsed-time reference model.
module tb_amux_bbm_sequencer;

   localparam int N  = 8;
   localparam int CW = 4;
   localparam int B  = 4;
   localparam int S  = 16;

   logic          clock = 1'b0;
   logic          resetn;
   logic          req_valid;
   logic          req_ready;
   logic          req_bus;
   logic [CW-1:0] req_ch;
   logic          req_off;
   logic [N-1:0]  amux_a_en;
   logic [N-1:0]  amux_b_en;
   logic          busy;
   logic          settled_a;
   logic          settled_b;
   logic          err;

   int total = 0;
   int bad   = 0;

   // Reference model: channel per bus (-1 = open) and the age of the active sequence.
   int m_a, m_b;
   bit m_set_a, m_set_b, m_busy, m_err;
   bit s_bus, s_off;
   int s_ch, s_age;

   amux_bbm_sequencer #(
      .N_CH(N), .CH_W(CW), .BREAK_CYCLES(B), .SETTLE_CYCLES(S), .CNT_W(8)
   ) dut (
      .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_bus(req_bus), .req_ch(req_ch), .req_off(req_off),
      .amux_a_en(amux_a_en), .amux_b_en(amux_b_en), .busy(busy),
      .settled_a(settled_a), .settled_b(settled_b), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] vec(input int ch);
      logic [N-1:0] v;
      v = '0;
      if (ch >= 0) v[ch] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_a = -1; m_b = -1;
      m_set_a = 0; m_set_b = 0; m_busy = 0; m_err = 0;
      s_age = 0;
   endtask

   task automatic model_edge(input bit v, input bit bus, input int ch, input bit off);
      int tgt, oth;
      m_err = 0;
      if (!m_busy) begin
         if (v) begin
            tgt = bus ? m_b : m_a;
            oth = bus ? m_a : m_b;
            if (!off && (ch >= N || ch == oth)) begin
               m_err = 1;
            end else if (!((off && tgt == -1) || (!off && tgt == ch))) begin
               if (bus) begin m_b = -1; m_set_b = 0; end
               else     begin m_a = -1; m_set_a = 0; end
               m_busy = 1; s_bus = bus; s_off = off; s_ch = ch; s_age = 0;
            end
         end
      end else begin
         s_age++;
         if (s_age >= B) begin
            if (s_off) begin
               m_busy = 0;
            end else begin
               if (s_bus) m_b = s_ch; else m_a = s_ch;
               if (s_age >= B + S) begin
                  if (s_bus) m_set_b = 1; else m_set_a = 1;
                  m_busy = 0;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("a_en",      amux_a_en, vec(m_a));
      chk("b_en",      amux_b_en, vec(m_b));
      chk("busy",      busy,      m_busy);
      chk("req_ready", req_ready, !m_busy);
      chk("settled_a", settled_a, m_set_a);
      chk("settled_b", settled_b, m_set_b);
      chk("err",       err,       m_err);
   endtask

   // Called at a falling edge: drive, take one rising edge, check just after it.
   task automatic step(input bit v, input bit bus, input int ch, input bit off);
      req_valid = v;
      req_bus   = bus;
      req_ch    = CW'(ch);
      req_off   = off;
      @(posedge clock);
      model_edge(v, bus, ch, off);
      #1 check_all();
      @(negedge clock);
   endtask

   task automatic do_req(input bit bus, input int ch, input bit off);
      int n;
      step(1'b1, bus, ch, off);
      n = 0;
      while (m_busy && n < 40) begin
         step(1'b0, 1'b0, 0, 1'b0);
         n++;
      end
      chk("idle_bound", busy, 1'b0);
   endtask

   task automatic async_reset();
      resetn    = 1'b0;
      req_valid = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; req_valid = 1'b0; req_bus = 1'b0; req_ch = '0; req_off = 1'b0;
      model_reset();
      #12;
      check_all();
      @(negedge clock);
      resetn = 1'b1;

      do_req(1'b0, 3, 1'b0);              // A ch3
      do_req(1'b0, 5, 1'b0);              // A ch3 -> ch5, break first
      do_req(1'b1, 5, 1'b0);              // B ch5 conflicts with A
      do_req(1'b0, 9, 1'b0);              // out of range
      do_req(1'b0, 8, 1'b0);              // first out-of-range index
      do_req(1'b0, 5, 1'b0);              // no-op
      step(1'b1, 1'b1, 1, 1'b0);          // B ch1, reset mid-settle
      for (int i = 0; i < B + 3; i++) step(1'b0, 1'b0, 0, 1'b0);
      chk("mid_settle_b_en", amux_b_en, 8'h02);
      async_reset();
      step(1'b1, 1'b0, 5, 1'b0);          // accepted at first edge after release
      chk("accept_after_reset", busy, 1'b1);
      while (m_busy) step(1'b0, 1'b0, 0, 1'b0);
      do_req(1'b1, 1, 1'b0);
      do_req(1'b0, 0, 1'b1);              // A off, B untouched
      chk("b_kept", amux_b_en, 8'h02);
      do_req(1'b0, 0, 1'b1);              // off on open bus: no-op

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 9)), ($urandom_range(0, 4) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
